// File: rtl/sseg_pkg.sv
// Shared types and constants for the BCD seven-segment scan driver.
// Segment bytes are active-low {dp,g,f,e,d,c,b,a}; anode nibbles are active-low.
package sseg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

  localparam int unsigned IN_BITS  = 7;
  localparam int unsigned BCD_BITS = 12;

  // Step index of the seventh and final shift.
  localparam logic [2:0] LAST_STEP = 3'd6;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
    return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble converter: 7-bit binary to three BCD digits, one shift per cycle.
// done and hund/tens/ones are valid together in the final CONV cycle only.
//
// state | meaning
// IDLE  | waiting for load; accepts d_in and clears the accumulator
// CONV  | add-3 then shift once per cycle; leaves after step 6
module bcd_seq_conv
  import sseg_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [IN_BITS-1:0] d_in,
  output logic               busy,
  output logic               done,
  output logic [3:0]         hund,
  output logic [3:0]         tens,
  output logic [3:0]         ones
);

  conv_state_e         state_q, state_d;
  logic [IN_BITS-1:0]  shift_q, shift_d;
  logic [BCD_BITS-1:0] bcd_q, bcd_d;
  logic [2:0]          step_q, step_d;
  logic                busy_q, busy_d;

  logic [BCD_BITS-1:0] bcd_adj;
  logic [BCD_BITS-1:0] bcd_shifted;
  logic                done_c;

  always_comb begin
    bcd_adj     = {add3_if_ge5(bcd_q[11:8]), add3_if_ge5(bcd_q[7:4]), add3_if_ge5(bcd_q[3:0])};
    bcd_shifted = BCD_BITS'({bcd_adj, shift_q[IN_BITS-1]});

    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d = d_in;
          bcd_d   = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = bcd_shifted;
        shift_d = {shift_q[IN_BITS-2:0], 1'b0};
        step_d  = step_q + 3'd1;
        if (step_q == LAST_STEP) begin
          done_c  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_c;
  assign hund = bcd_shifted[11:8];
  assign tens = bcd_shifted[7:4];
  assign ones = bcd_shifted[3:0];

endmodule

// File: rtl/sseg_bcd_scan.sv
// Captures a 7-bit result, converts it to BCD and scans hundreds/tens/ones onto a 4-digit display.
// Define SSEG_LZ_BLANK_EN to blank leading zeros in the hundreds and tens slots.
module sseg_bcd_scan
  import sseg_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [IN_BITS-1:0] d_in,
  output logic               busy,
  output logic [3:0]         an,
  output logic [7:0]         sseg
);

  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [3:0]              hund_q, hund_d;
  logic [3:0]              tens_q, tens_d;
  logic [3:0]              ones_q, ones_d;
  logic [3:0]              an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;

  logic       conv_done;
  logic [3:0] conv_hund, conv_tens, conv_ones;
  logic [1:0] slot;
  logic       blank_hund, blank_tens;

  bcd_seq_conv u_conv (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d_in  (d_in),
    .busy  (busy),
    .done  (conv_done),
    .hund  (conv_hund),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

`ifdef SSEG_LZ_BLANK_EN
  assign blank_hund = (hund_q == 4'd0);
  assign blank_tens = (hund_q == 4'd0) && (tens_q == 4'd0);
`else
  assign blank_hund = 1'b0;
  assign blank_tens = 1'b0;
`endif

  assign slot = cnt_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    cnt_d  = cnt_q + REFRESH_BITS'(1);
    hund_d = hund_q;
    tens_d = tens_q;
    ones_d = ones_q;
    if (conv_done) begin
      hund_d = conv_hund;
      tens_d = conv_tens;
      ones_d = conv_ones;
    end

    // Outputs follow the slot of the counter value before this edge.
    an_d   = AN_OFF;
    sseg_d = SEG_BLANK;
    case (slot)
      2'd0: begin
        an_d   = AN_ONES;
        sseg_d = seg_decode(ones_q);
      end
      2'd1: begin
        if (!blank_tens) begin
          an_d   = AN_TENS;
          sseg_d = seg_decode(tens_q);
        end
      end
      2'd2: begin
        if (!blank_hund) begin
          an_d   = AN_HUND;
          sseg_d = seg_decode(hund_q);
        end
      end
      default: begin
        an_d   = AN_OFF;
        sseg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      hund_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
      an_q   <= AN_OFF;
      sseg_q <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      hund_q <= hund_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_bcd_scan.sv
// Directed bench for sseg_bcd_scan with a 4-bit scan counter (4 cycles per slot, 16 per frame).
module tb_sseg_bcd_scan;

`ifdef SSEG_LZ_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [6:0] d_in = '0;
  logic       busy;
  logic [3:0] an;
  logic [7:0] sseg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sseg_bcd_scan #(.REFRESH_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d_in  (d_in),
    .busy  (busy),
    .an    (an),
    .sseg  (sseg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic start(input logic [6:0] v);
    @(negedge clk);
    load = 1'b1;
    d_in = v;
  endtask

  // Counts busy cycles; optionally injects a load at busy cycle inj_cyc, asserts reset at
  // busy cycle rst_cyc, or issues a new load in the first idle cycle (chain).
  task automatic wait_conv(input int inj_cyc, input logic [6:0] inj_v, input int rst_cyc,
                           input bit chain, input logic [6:0] chain_v, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (!busy) begin
        if (chain) begin
          load = 1'b1;
          d_in = chain_v;
        end
        return;
      end
      n++;
      if (n == inj_cyc) begin
        load = 1'b1;
        d_in = inj_v;
      end
      if (n == rst_cyc) begin
        reset = 1'b0;
        #1;
        check("busy_on_reset", busy, 1'b0);
        check("an_on_reset", an, 4'b1111);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
    end
    check("conv_timeout", 1'b1, 1'b0);
  endtask

  task automatic check_disp(input string tag, input int h, input int t, input int o);
    logic [7:0] s_o, s_t, s_h;
    bit f_o, f_t, f_h;
    int bad;
    s_o = '0; s_t = '0; s_h = '0;
    f_o = 0; f_t = 0; f_h = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin f_o = 1; s_o = sseg; end
        4'b1101: begin f_t = 1; s_t = sseg; end
        4'b1011: begin f_h = 1; s_h = sseg; end
        4'b1111: if (sseg !== 8'hFF) bad++;
        default: bad++;
      endcase
    end
    check({tag, "_ones"}, {f_o, s_o}, {1'b1, exp_seg(o)});
    if (LZ_EN && h == 0 && t == 0) check({tag, "_tens_blank"}, f_t, 1'b0);
    else                           check({tag, "_tens"}, {f_t, s_t}, {1'b1, exp_seg(t)});
    if (LZ_EN && h == 0) check({tag, "_hund_blank"}, f_h, 1'b0);
    else                 check({tag, "_hund"}, {f_h, s_h}, {1'b1, exp_seg(h)});
    check({tag, "_off_slots"}, bad, 0);
  endtask

  initial begin
    int n;
    int slot;
    logic [3:0] e_an;
    logic [7:0] e_seg;

    repeat (3) @(negedge clk);
    check("rst_an", an, 4'b1111);
    check("rst_sseg", sseg, 8'hFF);
    check("rst_busy", busy, 1'b0);

    reset = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      slot = ((k - 1) >> 2) & 3;
      case (slot)
        0: begin e_an = 4'b1110; e_seg = 8'hC0; end
        1: begin e_an = LZ_EN ? 4'b1111 : 4'b1101; e_seg = LZ_EN ? 8'hFF : 8'hC0; end
        2: begin e_an = LZ_EN ? 4'b1111 : 4'b1011; e_seg = LZ_EN ? 8'hFF : 8'hC0; end
        default: begin e_an = 4'b1111; e_seg = 8'hFF; end
      endcase
      check($sformatf("scan_an_%0d", k), an, e_an);
      check($sformatf("scan_sseg_%0d", k), sseg, e_seg);
    end

    start(7'd127);
    wait_conv(0, 7'd0, 0, 1'b0, 7'd0, n);
    check("busy_len_127", n, 7);
    check_disp("d127", 1, 2, 7);

    start(7'd5);
    wait_conv(0, 7'd0, 0, 1'b0, 7'd0, n);
    check("busy_len_5", n, 7);
    check_disp("d5", 0, 0, 5);

    start(7'd42);
    wait_conv(3, 7'd99, 0, 1'b0, 7'd0, n);
    check("busy_len_42_inj", n, 7);
    check_disp("d42", 0, 4, 2);

    start(7'd88);
    wait_conv(7, 7'd11, 0, 1'b1, 7'd63, n);
    check("busy_len_88_e7", n, 7);
    wait_conv(0, 7'd0, 0, 1'b0, 7'd0, n);
    check("busy_len_63_b2b", n, 7);
    check_disp("d63", 0, 6, 3);

    start(7'd100);
    wait_conv(0, 7'd0, 4, 1'b0, 7'd0, n);
    check("busy_len_100_rst", n, 4);
    check_disp("d_rst", 0, 0, 0);

    start(7'd100);
    wait_conv(0, 7'd0, 0, 1'b0, 7'd0, n);
    check("busy_len_100", n, 7);
    check_disp("d100", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sseg_bcd_scan.md
# sseg_bcd_scan

Sequential display driver downstream of the `asm_ex` datapath. It captures the 7-bit result `dout` on the `done_tick` strobe and converts it to three BCD digits with a multi-cycle shift-add-3 (double-dabble) engine. It then time-multiplexes the hundreds, tens and ones digits onto the 4-digit active-low seven-segment display, replacing the combinational value-to-segment path in the top level.

## Interface
- `REFRESH_BITS`, default 18: width of the free-running scan counter. The top 2 bits select the digit slot.
- `clk`  in  1  system clock; all flops on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  single-cycle strobe. Driven by `done_tick`.
- `d_in`  in  7  unsigned value, 0–127. Sampled only when `load` is accepted.
- `busy`  out  1  high while a conversion is in progress.
- `an`  out  4  digit enables, active-low. `an[0]` = ones, `an[1]` = tens, `an[2]` = hundreds, `an[3]` = unused.
- `sseg`  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a`}`. `dp` is always 1.

## Operation
- FSM states: IDLE and CONV.
- IDLE:
  - `load`=1 copies `d_in` into a 7-bit shift register, clears the 12-bit BCD accumulator and the 3-bit step counter, and moves to CONV.
- CONV, once per cycle:
  - Every BCD nibble ≥5 gets +3.
  - The {BCD, shift} pair then shifts left 1, bringing in the shift-register MSB.
  - Step counter increments.
  - On the 7th shift (step==6), the result goes into the display registers `hund`/`tens`/`ones` (4 bits each) and the FSM returns to IDLE.
- `load` during CONV is ignored: no queueing, the conversion in flight is not disturbed.
- Display registers change only on conversion completion. The previous value stays shown while `busy`.
- Scan counter: `REFRESH_BITS` wide, free-running, wraps modulo 2^`REFRESH_BITS`. Slot = counter[MSB:MSB-1].
  - Slot 0: ones on `an`=1110.
  - Slot 1: tens on `an`=1101.
  - Slot 2: hundreds on `an`=1011.
  - Slot 3: all off, `an`=1111, `sseg`=FF.
- Segment patterns, hex: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Any BCD value >9 cannot occur. If it does, the decoder outputs FF.

## Timing
- Reset values:
  - State IDLE, `busy`=0, display registers 0, scan counter 0.
  - `an`=1111, `sseg`=FF.
- `an`/`sseg` are registered, one cycle behind the scan counter. The first edge after reset release gives `an`=1110, `sseg`=C0.
- Conversion latency:
  - `load` is sampled at edge E0.
  - `busy` goes high after E0 and falls after E7 (7 cycles high).
  - Display registers update at E7. The new digit appears on the first registered scan output of its slot after E7.
- `load` coincident with the E7 completion edge is ignored; the FSM is still in CONV.
- `load` in the first IDLE cycle after completion is accepted, so back-to-back conversions run every 8 cycles.
- Reset asserted mid-conversion: immediate return to IDLE, conversion discarded, display shows 0.

## Configuration
- `SSEG_LZ_BLANK_EN` defined (leading-zero blanking):
  - Hundreds is blanked when `hund`==0.
  - Tens is blanked when `hund`==0 and `tens`==0.
  - Ones is never blanked.
  - A blanked slot drives `an`=1111, `sseg`=FF.
- Not defined: all three digits are always lit, e.g. 5 shows "005".

## Structure
- Package `sseg_pkg`:
  - FSM state enum (IDLE, CONV).
  - The 10 segment-pattern constants and the blank constant FF.
  - Anode constants for slots 0–3.
- Sub-module `bcd_seq_conv` holds the FSM, shift register, step counter and add-3 logic. Ports: `clk`, `reset`, `load`, `d_in`, `busy`, `done`, `hund`, `tens`, `ones`.
- The top level keeps the scan counter, display registers, blanking and segment decode.

## Test plan
- Hold `reset`=0 → `an`=1111, `sseg`=FF, `busy`=0. Release → next edge gives `an`=1110, `sseg`=C0.
- `load`=1 with `d_in`=127 → `busy` high exactly 7 cycles. Then slots show ones F8, tens A4, hundreds F9, slot 3 FF.
- `d_in`=5, macro defined → `an[1]`, `an[2]` never low; ones=92. Macro undefined → tens and hundreds show C0.
- `d_in`=42 loaded, then `load` with `d_in`=99 at cycle 3 of `busy` → display 0/4/2 (hundreds/tens/ones). 99 is dropped and `busy` is not extended.
- `load` `d_in`=100, reset at cycle 4 of `busy` → `busy`=0 immediately, display 000. A later `load` of 100 displays 1/0/0.
- `REFRESH_BITS`=4 → `an` cycles 1110, 1101, 1011, 1111, each for 4 cycles, wrapping after 16.
